// File: rtl/dice_bank.sv
// Multi-die electronic dice bank: odometer-chained dice roll while button is held, then settle to a registered total.
// Optional DICE_DOUBLES_DETECT_EN adds a registered "all dice equal" flag.
module dice_bank #(
  parameter int N_DICE = 2,
  parameter int FACES  = 6,
  parameter int W      = 3,
  parameter int SUM_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  input  logic [N_DICE-1:0]   hold,
  output logic [N_DICE*W-1:0] throws,
  output logic [SUM_W-1:0]    total,
  output logic                valid
`ifdef DICE_DOUBLES_DETECT_EN
  ,
  output logic                doubles
`endif
);

  typedef enum logic [1:0] {IDLE, ROLLING, SETTLE, DONE} state_t;

  localparam logic [W-1:0] FACE_MAX = W'(FACES);
  localparam logic [W-1:0] ONE      = W'(1);

  state_t              state;
  logic [N_DICE*W-1:0] dice_q;
  logic [N_DICE*W-1:0] dice_adv;
  logic [N_DICE*W-1:0] dice_fix;
  logic [N_DICE:0]     carry;
  logic [SUM_W-1:0]    sum;
  logic                all_eq;

  assign throws = dice_q;

  // dice_adv is the odometer step; dice_fix only repairs out-of-range dice.
  // An illegal die always reloads to 1 and breaks the carry chain.
  always_comb begin
    dice_adv = dice_q;
    dice_fix = dice_q;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < N_DICE; i++) begin
      logic [W-1:0] v;
      v = dice_q[i*W +: W];
      if (v == '0 || v > FACE_MAX) begin
        dice_adv[i*W +: W] = ONE;
        dice_fix[i*W +: W] = ONE;
        carry[i+1]         = 1'b0;
      end else if (hold[i]) begin
        carry[i+1] = carry[i];
      end else if (carry[i]) begin
        if (v == FACE_MAX) begin
          dice_adv[i*W +: W] = ONE;
          carry[i+1]         = 1'b1;
        end else begin
          dice_adv[i*W +: W] = v + ONE;
        end
      end
    end
  end

  always_comb begin
    sum    = '0;
    all_eq = 1'b1;
    for (int i = 0; i < N_DICE; i++) begin
      sum = sum + SUM_W'(dice_q[i*W +: W]);
      if (dice_q[i*W +: W] != dice_q[W-1:0])
        all_eq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dice_q <= {N_DICE{ONE}};
      total  <= SUM_W'(N_DICE);
      valid  <= 1'b0;
`ifdef DICE_DOUBLES_DETECT_EN
      doubles <= 1'b0;
`endif
    end else begin
      dice_q <= dice_fix;
      case (state)
        IDLE, DONE: begin
          if (button) begin
            state  <= ROLLING;
            valid  <= 1'b0;
            dice_q <= dice_adv;
`ifdef DICE_DOUBLES_DETECT_EN
            doubles <= 1'b0;
`endif
          end
        end
        ROLLING: begin
          if (button)
            dice_q <= dice_adv;
          else
            state <= SETTLE;
        end
        SETTLE: begin
          state <= DONE;
          total <= sum;
          valid <= 1'b1;
`ifdef DICE_DOUBLES_DETECT_EN
          doubles <= all_eq;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DICE_DOUBLES_DETECT_EN
  logic unused_all_eq;
  assign unused_all_eq = all_eq;
`endif

endmodule
